out_stream_framer: RTL

OUT_STREAM_FRAMER -- requirements
Module: out_stream_framer

---
 rtl/out_stream_framer.sv | 109 ++++++++++
 1 files changed

// File: rtl/out_stream_framer.sv
// rtl/out_stream_framer.sv - buffers pushed words in a circular FIFO and emits them as framed stream runs
module out_stream_framer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  frame_len,
   input  logic [CNT_WIDTH-1:0]  num_frames,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_wr,
   output logic                  in_full,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  frame_count,
   output logic                  ovf_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           fifo_count;
   logic [CNT_WIDTH-1:0]  beat_cnt, len_q, nf_q, frame_count_q;
   logic                  ovf_q;
   logic                  init, active, wr_acc, beat, last_beat, run_end;

   assign init      = reset | clear;
   assign active    = (state == S_ACTIVE);
   assign in_full   = !active || (fifo_count == FULL_CNT);
   assign out_valid = active && (fifo_count != '0);
   assign out_last  = out_valid && (beat_cnt == len_q - CNT_WIDTH'(1));
   assign wr_acc    = in_wr && !in_full;
   assign beat      = out_valid && out_ready;
   assign last_beat = beat && out_last;
   // nf_q == 0 selects continuous mode, so only a counted run can end
   assign run_end   = last_beat && (nf_q != '0) && (frame_count_q + CNT_WIDTH'(1) == nf_q);

   assign out_data    = mem[rd_ptr];
   assign busy        = active;
   assign done        = (state == S_DONE);
   assign frame_count = frame_count_q;
   assign ovf_err     = ovf_q;

   always_ff @(posedge clock) begin
      if (init) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_ACTIVE;
         S_ACTIVE: if (run_end) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (wr_acc) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clock) begin
      if (init) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         beat_cnt      <= '0;
         frame_count_q <= '0;
         len_q         <= CNT_WIDTH'(1);
         nf_q          <= '0;
         ovf_q         <= 1'b0;
      end else begin
         if (in_wr && in_full) ovf_q <= 1'b1;
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (beat)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, beat})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         // buffered words survive the run boundary; only the counters restart
         if (state == S_IDLE && start) begin
            len_q         <= (frame_len == '0) ? CNT_WIDTH'(1) : frame_len;
            nf_q          <= num_frames;
            beat_cnt      <= '0;
            frame_count_q <= '0;
         end else if (last_beat) begin
            beat_cnt      <= '0;
            frame_count_q <= frame_count_q + CNT_WIDTH'(1);
         end else if (beat) begin
            beat_cnt      <= beat_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule
